// File: rtl/arp_eth_tx_pkg.sv
// Shared ARP constants, TX state encoding and the ARP body packer.
// arp_pack returns the 28-byte ARP body flattened with byte 0 in bits [7:0],
// byte 27 in bits [223:216].
package arp_eth_tx_pkg;
  localparam int ARP_HDR_LEN     = 28;
  localparam int ETH_MIN_PAYLOAD = 46;

  localparam logic [7:0]  ARP_HLEN = 8'd6;
  localparam logic [7:0]  ARP_PLEN = 8'd4;

  localparam logic [15:0] ETHERTYPE_ARP    = 16'h0806;
  localparam logic [15:0] ARP_HTYPE_ETH    = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4   = 16'h0800;
  localparam logic [15:0] ARP_OPER_REQUEST = 16'd1;
  localparam logic [15:0] ARP_OPER_REPLY   = 16'd2;

  typedef enum logic {ST_IDLE, ST_SEND} tx_state_e;

  // Fields are network (MSB-first) order on the wire; flip the big-endian
  // concatenation so byte 0 lands in the low bits.
  function automatic logic [ARP_HDR_LEN*8-1:0] arp_pack(
    input logic [15:0] htype, input logic [15:0] ptype, input logic [15:0] oper,
    input logic [47:0] sha,   input logic [31:0] spa,
    input logic [47:0] tha,   input logic [31:0] tpa);
    logic [ARP_HDR_LEN*8-1:0] be, le;
    be = {htype, ptype, ARP_HLEN, ARP_PLEN, oper, sha, spa, tha, tpa};
    for (int i = 0; i < ARP_HDR_LEN; i++)
      le[i*8 +: 8] = be[(ARP_HDR_LEN-1-i)*8 +: 8];
    return le;
  endfunction
endpackage

// File: rtl/arp_eth_tx_if.sv
// Ethernet TX side of the ARP serialiser: parallel header handshake plus the
// AXI-stream payload. master = frame producer (arp_eth_tx), slave = consumer.
interface arp_eth_tx_if #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH/8
);
  logic                  m_eth_hdr_valid;
  logic                  m_eth_hdr_ready;
  logic [47:0]           m_eth_dest_mac;
  logic [47:0]           m_eth_src_mac;
  logic [15:0]           m_eth_type;
  logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata;
  logic [KEEP_WIDTH-1:0] m_eth_payload_axis_tkeep;
  logic                  m_eth_payload_axis_tvalid;
  logic                  m_eth_payload_axis_tready;
  logic                  m_eth_payload_axis_tlast;
  logic                  m_eth_payload_axis_tuser;

  modport master (
    output m_eth_hdr_valid, m_eth_dest_mac, m_eth_src_mac, m_eth_type,
           m_eth_payload_axis_tdata, m_eth_payload_axis_tkeep,
           m_eth_payload_axis_tvalid, m_eth_payload_axis_tlast,
           m_eth_payload_axis_tuser,
    input  m_eth_hdr_ready, m_eth_payload_axis_tready
  );
  modport slave (
    input  m_eth_hdr_valid, m_eth_dest_mac, m_eth_src_mac, m_eth_type,
           m_eth_payload_axis_tdata, m_eth_payload_axis_tkeep,
           m_eth_payload_axis_tvalid, m_eth_payload_axis_tlast,
           m_eth_payload_axis_tuser,
    output m_eth_hdr_ready, m_eth_payload_axis_tready
  );
endinterface

// File: rtl/arp_eth_tx.sv
// arp_eth_tx: serialises parallel ARP fields into an Ethernet header plus an
// AXI-stream payload carrying the ARP body (byte 0 in tdata[7:0]).
// Ports: clk, rst (sync, active-high); s_frame_valid/s_frame_ready with the
// s_eth_* / s_arp_* fields; m_eth (arp_eth_tx_if.master) header + payload;
// busy = frame in progress.
// Build option: ARP_TX_PAD_EN zero-pads the payload to 46 bytes.
module arp_eth_tx
  import arp_eth_tx_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = DATA_WIDTH/8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_frame_valid,
  output logic        s_frame_ready,
  input  logic [47:0] s_eth_dest_mac,
  input  logic [47:0] s_eth_src_mac,
  input  logic [15:0] s_eth_type,
  input  logic [15:0] s_arp_htype,
  input  logic [15:0] s_arp_ptype,
  input  logic [15:0] s_arp_oper,
  input  logic [47:0] s_arp_sha,
  input  logic [31:0] s_arp_spa,
  input  logic [47:0] s_arp_tha,
  input  logic [31:0] s_arp_tpa,
  arp_eth_tx_if.master m_eth,
  output logic        busy
);
`ifdef ARP_TX_PAD_EN
  localparam int FRAME_LEN = ETH_MIN_PAYLOAD;
`else
  localparam int FRAME_LEN = ARP_HDR_LEN;
`endif
  localparam int CYCLE_COUNT = (FRAME_LEN + KEEP_WIDTH - 1) / KEEP_WIDTH;
  localparam int PADW        = CYCLE_COUNT * DATA_WIDTH;
  localparam int REM         = FRAME_LEN % KEEP_WIDTH;
  localparam logic [KEEP_WIDTH-1:0] LAST_KEEP =
    (REM == 0) ? {KEEP_WIDTH{1'b1}} : KEEP_WIDTH'((1 << REM) - 1);
  localparam int PW = (CYCLE_COUNT > 1) ? $clog2(CYCLE_COUNT) : 1;

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_width
    $fatal(1, "arp_eth_tx: DATA_WIDTH must be a positive multiple of 8");
  end

  tx_state_e             state_q;
  logic [PW-1:0]         ptr_q;      // index of the next beat to load
  logic [PADW-1:0]       frame_in, frame_q;
  logic                  ready_q, hdr_valid_q, tvalid_q, tlast_q, busy_q;
  logic [47:0]           dest_q, src_q;
  logic [15:0]           type_q;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic [KEEP_WIDTH-1:0] tkeep_q;
  logic                  accept, beat_hs, hdr_valid_d, idle_d;

  assign accept  = s_frame_valid && ready_q;
  assign beat_hs = tvalid_q && m_eth.m_eth_payload_axis_tready;

  // Zero-extended to a whole number of beats, so padding and unused lanes
  // of the final beat fall out as zero bytes.
  always_comb begin
    frame_in = '0;
    frame_in[ARP_HDR_LEN*8-1:0] = arp_pack(s_arp_htype, s_arp_ptype, s_arp_oper,
                                           s_arp_sha, s_arp_spa, s_arp_tha, s_arp_tpa);
  end

  // ready is registered, so it looks one cycle ahead: idle next cycle and
  // no header still waiting to be consumed.
  always_comb begin
    hdr_valid_d = hdr_valid_q;
    if (accept)                      hdr_valid_d = 1'b1;
    else if (m_eth.m_eth_hdr_ready)  hdr_valid_d = 1'b0;
    idle_d = (state_q == ST_IDLE && !accept) ||
             (state_q == ST_SEND && beat_hs && tlast_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      ready_q     <= 1'b0;
      hdr_valid_q <= 1'b0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      ready_q     <= idle_d && !hdr_valid_d;
      hdr_valid_q <= hdr_valid_d;
      if (accept) begin
        dest_q <= s_eth_dest_mac;
        src_q  <= s_eth_src_mac;
        type_q <= s_eth_type;
      end
      case (state_q)
        ST_IDLE: if (accept) begin
          frame_q  <= frame_in;
          tdata_q  <= frame_in[DATA_WIDTH-1:0];
          tlast_q  <= (CYCLE_COUNT == 1);
          tkeep_q  <= (CYCLE_COUNT == 1) ? LAST_KEEP : {KEEP_WIDTH{1'b1}};
          tvalid_q <= 1'b1;
          ptr_q    <= PW'(1);
          busy_q   <= 1'b1;
          state_q  <= ST_SEND;
        end
        ST_SEND: if (beat_hs) begin
          if (tlast_q) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            busy_q   <= 1'b0;
            state_q  <= ST_IDLE;
          end else begin
            tdata_q <= frame_q[int'(ptr_q)*DATA_WIDTH +: DATA_WIDTH];
            tlast_q <= (int'(ptr_q) == CYCLE_COUNT-1);
            tkeep_q <= (int'(ptr_q) == CYCLE_COUNT-1) ? LAST_KEEP : {KEEP_WIDTH{1'b1}};
            ptr_q   <= ptr_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_frame_ready                   = ready_q;
  assign busy                            = busy_q;
  assign m_eth.m_eth_hdr_valid           = hdr_valid_q;
  assign m_eth.m_eth_dest_mac            = dest_q;
  assign m_eth.m_eth_src_mac             = src_q;
  assign m_eth.m_eth_type                = type_q;
  assign m_eth.m_eth_payload_axis_tdata  = tdata_q;
  assign m_eth.m_eth_payload_axis_tvalid = tvalid_q;
  assign m_eth.m_eth_payload_axis_tlast  = tlast_q;
  assign m_eth.m_eth_payload_axis_tuser  = 1'b0;
  assign m_eth.m_eth_payload_axis_tkeep  = (KEEP_ENABLE != 0) ? tkeep_q : {KEEP_WIDTH{1'b1}};
endmodule

// File: tb/tb_arp_eth_tx.sv
// Bench for arp_eth_tx: an 8-bit instance for timing/stall/reset scenarios
// and a wide instance (64-bit, or 32-bit when ARP_TX_PAD_EN) for beat packing.
module tb_arp_eth_tx;
  import arp_eth_tx_pkg::*;
`ifdef ARP_TX_PAD_EN
  localparam int WW = 32;
  localparam int L  = ETH_MIN_PAYLOAD;
  localparam logic [63:0] BEAT0W = 64'h0000_0000_0008_0100;
`else
  localparam int WW = 64;
  localparam int L  = ARP_HDR_LEN;
  localparam logic [63:0] BEAT0W = 64'h0200_0406_0008_0100;
`endif
  localparam int KWW = WW/8;

  typedef byte unsigned bq_t[$];

  logic clk = 1'b0, rst;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [15:0] htype, ptype, oper, etype;
  logic [47:0] sha, tha, dmac, smac;
  logic [31:0] spa, tpa;
  logic sv8, rdy8, busy8, svw, rdyw, busyw;

  arp_eth_tx_if #(.DATA_WIDTH(8))  if8 ();
  arp_eth_tx_if #(.DATA_WIDTH(WW)) ifw ();

  arp_eth_tx #(.DATA_WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .s_frame_valid(sv8), .s_frame_ready(rdy8),
    .s_eth_dest_mac(dmac), .s_eth_src_mac(smac), .s_eth_type(etype),
    .s_arp_htype(htype), .s_arp_ptype(ptype), .s_arp_oper(oper),
    .s_arp_sha(sha), .s_arp_spa(spa), .s_arp_tha(tha), .s_arp_tpa(tpa),
    .m_eth(if8), .busy(busy8));

  arp_eth_tx #(.DATA_WIDTH(WW)) uw (
    .clk(clk), .rst(rst), .s_frame_valid(svw), .s_frame_ready(rdyw),
    .s_eth_dest_mac(dmac), .s_eth_src_mac(smac), .s_eth_type(etype),
    .s_arp_htype(htype), .s_arp_ptype(ptype), .s_arp_oper(oper),
    .s_arp_sha(sha), .s_arp_spa(spa), .s_arp_tha(tha), .s_arp_tpa(tpa),
    .m_eth(ifw), .busy(busyw));

  // Reference: wire order of the ARP body, fields MSB-first, then zero pad.
  function automatic bq_t arp_model();
    bq_t b;
    logic [63:0] f[9];
    int n[9];
    f = '{htype, ptype, 64'd6, 64'd4, oper, sha, spa, tha, tpa};
    n = '{2, 2, 1, 1, 2, 6, 4, 6, 4};
    for (int k = 0; k < 9; k++)
      for (int i = n[k]-1; i >= 0; i--) b.push_back(8'(f[k] >> (8*i)));
    while (b.size() < L) b.push_back(8'h00);
    return b;
  endfunction

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cmpq(input string tag, input bq_t a, input bq_t e);
    int i = 0;
    chk({tag, "_len"}, 64'(a.size()), 64'(e.size()));
    while (i < a.size() && i < e.size() && a[i] == e[i]) i++;
    if (i < a.size() && i < e.size()) chk({tag, "_byte"}, 64'(a[i]), 64'(e[i]));
    else chk({tag, "_end"}, 64'(i), 64'(e.size()));
  endtask

  // ---------------- monitors / scoreboards ----------------
  bq_t q8, e8, qw, ew;
  int nb8, nl8, li8, ue8, se8, re8;
  int nbw, nlw, uew, pew;
  int acc8[$];
  logic [63:0] firstw;
  logic [KWW-1:0] lkw;
  logic st8, pl8;
  logic [7:0] pd8;

  always @(negedge clk) begin : mon8
    bq_t t;
    if (rst) st8 = 1'b0;
    else begin
      if (st8 && (!if8.m_eth_payload_axis_tvalid || if8.m_eth_payload_axis_tdata !== pd8 ||
                  if8.m_eth_payload_axis_tlast !== pl8)) se8++;
      if (if8.m_eth_hdr_valid && rdy8) re8++;
      if (sv8 && rdy8) begin
        acc8.push_back(cyc);
        t = arp_model();
        foreach (t[i]) e8.push_back(t[i]);
      end
      if (if8.m_eth_payload_axis_tvalid && if8.m_eth_payload_axis_tready) begin
        q8.push_back(if8.m_eth_payload_axis_tdata);
        if (if8.m_eth_payload_axis_tuser) ue8++;
        if (if8.m_eth_payload_axis_tlast) begin nl8++; li8 = nb8; end
        nb8++;
      end
      st8 = if8.m_eth_payload_axis_tvalid && !if8.m_eth_payload_axis_tready;
      pd8 = if8.m_eth_payload_axis_tdata;
      pl8 = if8.m_eth_payload_axis_tlast;
    end
  end

  always @(negedge clk) begin : monw
    bq_t t;
    if (!rst) begin
      if (svw && rdyw) begin
        t = arp_model();
        foreach (t[i]) ew.push_back(t[i]);
      end
      if (ifw.m_eth_payload_axis_tvalid && ifw.m_eth_payload_axis_tready) begin
        for (int j = 0; j < KWW; j++)
          if (ifw.m_eth_payload_axis_tkeep[j]) qw.push_back(ifw.m_eth_payload_axis_tdata[j*8 +: 8]);
          else if (ifw.m_eth_payload_axis_tdata[j*8 +: 8] != 8'h00) pew++;
        if (nbw == 0) firstw = 64'(ifw.m_eth_payload_axis_tdata);
        if (ifw.m_eth_payload_axis_tuser) uew++;
        if (ifw.m_eth_payload_axis_tlast) begin nlw++; lkw = ifw.m_eth_payload_axis_tkeep; end
        nbw++;
      end
    end
  end

  task automatic clr();
    q8.delete(); e8.delete(); qw.delete(); ew.delete(); acc8.delete();
    nb8 = 0; nl8 = 0; li8 = -1; ue8 = 0; se8 = 0; re8 = 0;
    nbw = 0; nlw = 0; uew = 0; pew = 0; firstw = '0; lkw = '0;
  endtask

  task automatic set_plan();
    htype = ARP_HTYPE_ETH; ptype = ARP_PTYPE_IPV4; oper = ARP_OPER_REPLY;
    sha = 48'h02_00_00_00_00_01; spa = 32'hC0A8010A;
    tha = 48'h5A_51_52_53_54_55; tpa = 32'hC0A80114;
    dmac = tha; smac = sha; etype = ETHERTYPE_ARP;
  endtask

  task automatic set_rand();
    htype = 16'($urandom); ptype = 16'($urandom);
    oper  = ($urandom % 2 != 0) ? ARP_OPER_REQUEST : ARP_OPER_REPLY;
    sha = 48'({$urandom, $urandom}); tha = 48'({$urandom, $urandom});
    spa = $urandom; tpa = $urandom;
    dmac = 48'({$urandom, $urandom}); smac = sha; etype = 16'($urandom);
  endtask

  // Polls s_frame_ready of the 8-bit DUT, then steps past the accept edge.
  task automatic accept8(input string tag);
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (rdy8) ok = 1;
    end
    chk(tag, 64'(ok), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy8 && !busyw) break;
    end
    chk(tag, 64'(busy8 | busyw), 64'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int sp;
    logic [KWW-1:0] ekw;
    rst = 1; sv8 = 0; svw = 0;
    if8.m_eth_hdr_ready = 1; if8.m_eth_payload_axis_tready = 1;
    ifw.m_eth_hdr_ready = 1; ifw.m_eth_payload_axis_tready = 1;
    set_plan(); clr();

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",     64'(rdy8), 0);
    chk("rst_hdr_valid", 64'(if8.m_eth_hdr_valid), 0);
    chk("rst_tvalid",    64'(if8.m_eth_payload_axis_tvalid), 0);
    chk("rst_tlast",     64'(if8.m_eth_payload_axis_tlast), 0);
    chk("rst_tuser",     64'(if8.m_eth_payload_axis_tuser), 0);
    chk("rst_busy",      64'(busy8), 0);
    @(posedge clk); #1 rst = 0;
    @(posedge clk);
    @(negedge clk);
    chk("idle_ready", 64'(rdy8), 1);

    // directed reply frame on both widths, ready=1
    @(posedge clk); #1 sv8 = 1; svw = 1;
    @(negedge clk);
    chk("plan_rdy8", 64'(rdy8), 1);
    chk("plan_rdyw", 64'(rdyw), 1);
    @(posedge clk); #1 sv8 = 0; svw = 0;
    @(negedge clk);
    chk("lat_hdr_valid8", 64'(if8.m_eth_hdr_valid), 1);
    chk("lat_tvalid8",    64'(if8.m_eth_payload_axis_tvalid), 1);
    chk("lat_busy8",      64'(busy8), 1);
    chk("lat_hdr_validw", 64'(ifw.m_eth_hdr_valid), 1);
    chk("hdr_dest",       if8.m_eth_dest_mac, 64'h5A5152535455);
    chk("hdr_type",       64'(if8.m_eth_type), 64'h0806);
    wait_idle("plan_done");
    cmpq("plan8", q8, e8);
    chk("plan8_b1",   64'(q8[1]), 64'h01);
    chk("plan8_b7",   64'(q8[7]), 64'h02);
    chk("plan8_b27",  64'(q8[27]), 64'h14);
    chk("plan8_nb",   64'(nb8), 64'(L));
    chk("plan8_nl",   64'(nl8), 1);
    chk("plan8_li",   64'(li8), 64'(L-1));
    chk("plan8_user", 64'(ue8), 0);
    cmpq("planw", qw, ew);
    chk("planw_nb",    64'(nbw), 64'((L + KWW - 1) / KWW));
    chk("planw_beat0", firstw, BEAT0W);
    ekw = (L % KWW != 0) ? KWW'((1 << (L % KWW)) - 1) : {KWW{1'b1}};
    chk("planw_lkeep", 64'(lkw), 64'(ekw));
    chk("planw_nl",    64'(nlw), 1);
    chk("planw_pad",   64'(pew), 0);
    chk("planw_user",  64'(uew), 0);

    // random tready, header stalled well past payload completion
    clr(); set_rand();
    if8.m_eth_hdr_ready = 0;
    @(posedge clk); #1 sv8 = 1;
    accept8("stall_acc");
    sv8 = 0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1 if8.m_eth_payload_axis_tready = ($urandom % 2 != 0);
      @(negedge clk);
      if (!busy8 && i >= 40) break;
    end
    #1 if8.m_eth_payload_axis_tready = 1;
    chk("stall_done", 64'(busy8), 0);
    repeat (3) @(negedge clk);
    chk("stall_blk_ready", 64'(rdy8), 0);
    chk("stall_hdr_held",  64'(if8.m_eth_hdr_valid), 1);
    @(posedge clk); #1 if8.m_eth_hdr_ready = 1;
    @(posedge clk);
    @(negedge clk);
    chk("stall_hdr_drop", 64'(if8.m_eth_hdr_valid), 0);
    chk("stall_ready",    64'(rdy8), 1);
    chk("stall_stable",   64'(se8), 0);
    chk("stall_rdy_hdr",  64'(re8), 0);
    cmpq("stall8", q8, e8);

    // three back-to-back frames
    clr(); set_rand();
    @(posedge clk); #1 sv8 = 1;
    for (int k = 0; k < 3; k++) begin
      accept8("b2b_acc");
      set_rand();
      if (k == 2) sv8 = 0;
    end
    wait_idle("b2b_done");
    chk("b2b_accepts", 64'(acc8.size()), 3);
    for (int k = 1; k < 3 && k < acc8.size(); k++) begin
      sp = acc8[k] - acc8[k-1];
      chk("b2b_spacing", 64'(sp), 64'(L + 1));
    end
    chk("b2b_nl", 64'(nl8), 3);
    cmpq("b2b8", q8, e8);

    // reset mid-frame, then a clean frame
    clr(); set_rand();
    @(posedge clk); #1 sv8 = 1;
    accept8("mid_acc");
    sv8 = 0;
    for (int i = 0; i < 100 && nb8 < 10; i++) @(negedge clk);
    chk("mid_reached", 64'(nb8 >= 10), 1);
    @(posedge clk); #1 rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_tvalid",    64'(if8.m_eth_payload_axis_tvalid), 0);
    chk("mid_hdr_valid", 64'(if8.m_eth_hdr_valid), 0);
    chk("mid_busy",      64'(busy8), 0);
    @(posedge clk); #1 rst = 0;
    clr(); set_rand();
    @(posedge clk); #1 sv8 = 1;
    accept8("post_acc");
    sv8 = 0;
    wait_idle("post_done");
    cmpq("post8", q8, e8);
    chk("post8_nb", 64'(nb8), 64'(L));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
